// File: rtl/pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch
// Purpose  : IF stage and IF/ID register with req/ready instruction fetch,
//            delay-slot redirect and one-entry stall buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_dpc4;
  logic [31:0] r_dinst;
  logic [31:0] r_buf_inst;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;

  logic        w_run;
  logic        w_avail;
  logic        w_deliver;
  logic        w_redirect;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic [31:0] w_target;

  assign w_run      = (r_state == ST_RUN);
  assign w_avail    = (w_run && imem_ready) || !w_run;
  assign w_deliver  = w_avail && nostall;
  assign w_inst     = w_run ? imem_rdata : r_buf_inst;
  assign w_pc4      = r_pc + 32'd4;
  assign w_redirect = (pcsource != 2'b00);

  always_comb begin
    w_target = jpc;
    case (pcsource)
      2'b01:   w_target = bpc;
      2'b10:   w_target = rpc;
      default: w_target = jpc;
    endcase
  end

  // A redirect seen while the delay slot is still in flight is parked in
  // r_redir_pc and applied once that delay slot is delivered.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_dpc4        <= 32'd0;
      r_dinst       <= NOP_INST;
      r_buf_inst    <= 32'd0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'd0;
    end else if (w_deliver) begin
      r_dinst       <= w_inst;
      r_dpc4        <= w_pc4;
      r_state       <= ST_RUN;
      r_redir_valid <= 1'b0;
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (r_redir_valid) begin
        r_pc <= r_redir_pc;
      end else begin
        r_pc <= w_pc4;
      end
    end else if (w_run && imem_ready && !nostall) begin
      r_buf_inst <= imem_rdata;
      r_state    <= ST_HELD;
    end else if (!w_avail && nostall) begin
      r_dinst <= NOP_INST;
      if (w_redirect) begin
        r_redir_valid <= 1'b1;
        r_redir_pc    <= w_target;
      end
    end
  end

  assign imem_req  = w_run;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign dpc4      = r_dpc4;
  assign dinst     = r_dinst;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fetch
// Purpose  : Directed self-checking bench for pipe_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch;

  logic        clk;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic        nostall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] dpc4;
  logic [31:0] dinst;

  int n_cmp = 0;
  int n_mis = 0;

  pipe_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) u_dut (
    .clk        (clk),
    .clrn       (clrn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .nostall    (nostall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .dpc4       (dpc4),
    .dinst      (dinst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word at address A is A ^ 32'hC0DE_0000.
  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clrn       = 1'b0;
    pcsource   = 2'b00;
    bpc        = 32'd0;
    rpc        = 32'd0;
    jpc        = 32'd0;
    nostall    = 1'b0;
    imem_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_dinst", dinst, 32'h0000_0000);
    chk("rst_dpc4",  dpc4,  32'h0000_0000);
    chk("rst_pc",    pc,    32'h0000_0000);
    chk("rst_req",   {31'd0, imem_req}, 32'd1);
    chk("rst_addr",  imem_addr, 32'h0000_0000);

    // Streaming, zero-wait memory
    clrn       = 1'b1;
    imem_ready = 1'b1;
    nostall    = 1'b1;
    step();
    chk("s0_dinst", dinst, 32'hC0DE_0000);
    chk("s0_dpc4",  dpc4,  32'h0000_0004);
    chk("s0_addr",  imem_addr, 32'h0000_0004);
    step();
    chk("s1_dinst", dinst, 32'hC0DE_0004);
    chk("s1_dpc4",  dpc4,  32'h0000_0008);
    chk("s1_addr",  imem_addr, 32'h0000_0008);

    // ID stall with instruction at 8 ready: buffered, outputs hold
    nostall = 1'b0;
    step();
    chk("st_dinst", dinst, 32'hC0DE_0004);
    chk("st_dpc4",  dpc4,  32'h0000_0008);
    chk("st_req",   {31'd0, imem_req}, 32'd0);
    chk("st_pc",    pc,    32'h0000_0008);
    nostall = 1'b1;
    step();
    chk("st_rel_dinst", dinst, 32'hC0DE_0008);
    chk("st_rel_dpc4",  dpc4,  32'h0000_000C);
    chk("st_rel_addr",  imem_addr, 32'h0000_000C);
    chk("st_rel_req",   {31'd0, imem_req}, 32'd1);
    step();
    chk("s3_dinst", dinst, 32'hC0DE_000C);
    chk("s3_pc",    pc,    32'h0000_0010);

    // Branch with zero-wait memory: delay slot at 0x10 delivered, then 0x40
    pcsource = 2'b01;
    bpc      = 32'h0000_0040;
    step();
    chk("br_dinst", dinst, 32'hC0DE_0010);
    chk("br_dpc4",  dpc4,  32'h0000_0014);
    chk("br_addr",  imem_addr, 32'h0000_0040);

    // Jump while the delay slot at 0x40 is still waiting on memory
    pcsource   = 2'b11;
    jpc        = 32'h0000_0100;
    imem_ready = 1'b0;
    step();
    chk("jw_bub_dinst", dinst, 32'h0000_0000);
    chk("jw_bub_dpc4",  dpc4,  32'h0000_0014);
    chk("jw_bub_addr",  imem_addr, 32'h0000_0040);
    pcsource = 2'b00;
    step();
    chk("jw_bub2_dinst", dinst, 32'h0000_0000);
    chk("jw_bub2_pc",    pc,    32'h0000_0040);
    imem_ready = 1'b1;
    step();
    chk("jw_ds_dinst", dinst, 32'hC0DE_0040);
    chk("jw_ds_dpc4",  dpc4,  32'h0000_0044);
    chk("jw_ds_addr",  imem_addr, 32'h0000_0100);

    // pcsource must be ignored while ID is stalled
    imem_ready = 1'b0;
    nostall    = 1'b0;
    pcsource   = 2'b01;
    bpc        = 32'h0000_0080;
    step();
    chk("ign_dinst", dinst, 32'hC0DE_0040);
    chk("ign_pc",    pc,    32'h0000_0100);
    pcsource   = 2'b00;
    nostall    = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("ign_rel_dinst", dinst, 32'hC0DE_0100);
    chk("ign_rel_pc",    pc,    32'h0000_0104);

    // Wrap-around at the top of the address space, then jr
    pcsource = 2'b11;
    jpc      = 32'hFFFF_FFFC;
    step();
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    step();
    chk("wr_dinst", dinst, 32'h3F21_FFFC);
    chk("wr_dpc4",  dpc4,  32'h0000_0000);
    chk("wr_pc0",   pc,    32'h0000_0000);
    pcsource = 2'b10;
    rpc      = 32'h0000_0200;
    step();
    chk("jr_dinst", dinst, 32'hC0DE_0000);
    chk("jr_dpc4",  dpc4,  32'h0000_0004);
    chk("jr_pc",    pc,    32'h0000_0200);

    // Reset asserted while HELD takes effect without a clock edge
    pcsource = 2'b00;
    nostall  = 1'b0;
    step();
    chk("h_req", {31'd0, imem_req}, 32'd0);
    clrn = 1'b0;
    #1;
    chk("ar_dinst", dinst, 32'h0000_0000);
    chk("ar_dpc4",  dpc4,  32'h0000_0000);
    chk("ar_pc",    pc,    32'h0000_0000);
    chk("ar_req",   {31'd0, imem_req}, 32'd1);
    step();
    clrn    = 1'b1;
    nostall = 1'b1;
    step();
    chk("ar_rel_dinst", dinst, 32'hC0DE_0000);
    chk("ar_rel_dpc4",  dpc4,  32'h0000_0004);
    chk("ar_rel_pc",    pc,    32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
